flag_event_monitor: RTL

//   Downstream stage of the 4-bit magnitude comparator; consumes its 2-bit flag result stream.

---
 rtl/cmp_pkg.sv | 18 +
 rtl/flag_event_monitor_if.sv | 25 ++
 rtl/sat_counter.sv | 31 +++
 rtl/flag_event_monitor.sv | 119 +++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the 4-bit comparator, its flag monitor and their benches.
package cmp_pkg;

    typedef logic [1:0] flag_t;

    localparam flag_t FLAG_EQ  = 2'b00;
    localparam flag_t FLAG_LT  = 2'b01;
    localparam flag_t FLAG_GT  = 2'b10;
    localparam flag_t FLAG_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        ALARM     = 2'b10,
        RELEASING = 2'b11
    } state_e;

endpackage

// File: rtl/flag_event_monitor_if.sv
// Flag stream in, event counts and alarm status out.
interface flag_event_monitor_if
    import cmp_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic             flag_valid;
    flag_t            flag;
    logic             clear;
    logic [CNT_W-1:0] cnt_less;
    logic [CNT_W-1:0] cnt_equal;
    logic [CNT_W-1:0] cnt_greater;
    logic             alarm;
    logic             err_illegal;

    modport master (
        output flag_valid, flag, clear,
        input  cnt_less, cnt_equal, cnt_greater, alarm, err_illegal
    );

    modport slave (
        input  flag_valid, flag, clear,
        output cnt_less, cnt_equal, cnt_greater, alarm, err_illegal
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/flag_event_monitor.sv
// Counts comparator flag classes and runs a GT/LT hysteresis alarm FSM.
module flag_event_monitor
    import cmp_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RUN_LEN = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    flag_event_monitor_if.slave  bus
);
    localparam logic [3:0] RunMax = 4'(RUN_LEN);

    logic       accept;
    logic       hit_lt, hit_eq, hit_gt, hit_ill;
    state_e     state_q;
    logic [3:0] run_q;
    logic       err_q;

    // Gating by accept keeps an undriven flag from reaching any state when invalid.
    assign accept  = bus.flag_valid && !bus.clear;
    assign hit_lt  = accept && (bus.flag == FLAG_LT);
    assign hit_eq  = accept && (bus.flag == FLAG_EQ);
    assign hit_gt  = accept && (bus.flag == FLAG_GT);
    assign hit_ill = accept && (bus.flag == FLAG_ILL);

    sat_counter #(.W(CNT_W)) u_cnt_less (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (hit_lt),
        .q     (bus.cnt_less)
    );

    sat_counter #(.W(CNT_W)) u_cnt_equal (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (hit_eq),
        .q     (bus.cnt_equal)
    );

    sat_counter #(.W(CNT_W)) u_cnt_greater (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (hit_gt),
        .q     (bus.cnt_greater)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 4'd0;
            err_q   <= 1'b0;
        end else if (bus.clear) begin
            state_q <= IDLE;
            run_q   <= 4'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (hit_ill) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (hit_gt && (RunMax == 4'd1)) begin
                        state_q <= ALARM;
                        run_q   <= 4'd0;
                    end else if (hit_gt) begin
                        state_q <= ARMING;
                        run_q   <= 4'd1;
                    end else begin
                        run_q   <= 4'd0;
                    end
                end
                ARMING: begin
                    if (hit_gt && ((run_q + 4'd1) >= RunMax)) begin
                        state_q <= ALARM;
                        run_q   <= 4'd0;
                    end else if (hit_gt) begin
                        run_q   <= run_q + 4'd1;
                    end else begin
                        state_q <= IDLE;
                        run_q   <= 4'd0;
                    end
                end
                ALARM: begin
                    if (hit_lt && (RunMax == 4'd1)) begin
                        state_q <= IDLE;
                        run_q   <= 4'd0;
                    end else if (hit_lt) begin
                        state_q <= RELEASING;
                        run_q   <= 4'd1;
                    end else begin
                        run_q   <= 4'd0;
                    end
                end
                RELEASING: begin
                    if (hit_lt && ((run_q + 4'd1) >= RunMax)) begin
                        state_q <= IDLE;
                        run_q   <= 4'd0;
                    end else if (hit_lt) begin
                        run_q   <= run_q + 4'd1;
                    end else begin
                        state_q <= ALARM;
                        run_q   <= 4'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.alarm       = (state_q == ALARM) || (state_q == RELEASING);
    assign bus.err_illegal = err_q;
endmodule
